ste_dma_sound_fetch: RTL

- Upstream feeder for the STE DMA-sound FIFO in the shifter.
- Holds the CPU-visible sound DMA registers: control, frame start, frame address counter and frame end.
- Watches the shifter's SREQ and, in granted memory slots, fetches sample words. It presents the word address, then pulses SLOAD_N so the shifter captures MDIN into its FIFO.
- Signals frame end for the MFP timer-A and GPIP7 logic, and handles one-shot and repeat playback.

---
 rtl/ste_dma_sound_fetch_if.sv | 31 +++
 rtl/ste_dma_sound_fetch.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ste_dma_sound_fetch_if.sv
// Bundle of the CPU register bus, the shifter FIFO handshake and the memory
// slot handshake seen by the STE DMA-sound fetch block.
//   master : drives CS/RW/A/DIN (CPU), SREQ (shifter), snd_slot (MCU timing)
//   slave  : the fetch block; returns DOUT, snd_req, snd_addr, SLOAD_N,
//            sint and sactive
interface ste_dma_sound_fetch_if #(
  parameter int ADDR_W = 21
);
  logic              CS;
  logic              RW;
  logic [4:0]        A;
  logic [7:0]        DIN;
  logic [15:0]       DOUT;
  logic              SREQ;
  logic              snd_slot;
  logic              snd_req;
  logic [ADDR_W-1:0] snd_addr;
  logic              SLOAD_N;
  logic              sint;
  logic              sactive;

  modport master (
    output CS, RW, A, DIN, SREQ, snd_slot,
    input  DOUT, snd_req, snd_addr, SLOAD_N, sint, sactive
  );

  modport slave (
    input  CS, RW, A, DIN, SREQ, snd_slot,
    output DOUT, snd_req, snd_addr, SLOAD_N, sint, sactive
  );
endinterface

// File: rtl/ste_dma_sound_fetch.sv
// STE DMA-sound fetch: holds the sound DMA registers (control, frame start,
// frame counter, frame end), requests memory slots while the shifter FIFO has
// room, presents the word address during a granted slot and strobes SLOAD_N
// when the RAM data is valid. Emits a one-cycle sint at each frame end and
// handles one-shot / repeat playback.
// Ports:
//   clk32 : system clock
//   resb  : synchronous active-low reset
//   bus   : ste_dma_sound_fetch_if.slave (CPU regs, SREQ, slot handshake,
//           SLOAD_N, sint, sactive)
//
// state | meaning
// IDLE  | not playing
// ARM   | playing; checks frame end, waits for FIFO room
// WAIT  | snd_req raised, waiting for a slot grant
// FETCH | slot granted, counting down to RAM data valid
module ste_dma_sound_fetch #(
  parameter int FETCH_LAT = 4,
  parameter int ADDR_W    = 21
) (
  input  logic                 clk32,
  input  logic                 resb,
  ste_dma_sound_fetch_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_FETCH} state_t;

  localparam int FW = $clog2(FETCH_LAT + 1);

  state_t            state_q, state_d;
  logic              cs_d_q;
  logic [1:0]        ctrl_q, ctrl_d;
  // address registers hold byte-address bits [ADDR_W:1]
  logic [ADDR_W:1]   start_q, end_q;
  logic [ADDR_W:1]   cnt_q, cnt_d;
  logic [ADDR_W:1]   end_l_q, end_l_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [ADDR_W-1:0] snd_addr_q, snd_addr_d;
  logic              sload_n_q, sload_n_d;
  logic              sint_q, sint_d;

  logic wr, ctrl_wr, play_now, reload;
  logic [15:0] rd;

  assign wr      = bus.CS & ~cs_d_q & ~bus.RW;
  assign ctrl_wr = wr & (bus.A == 5'd0);
  // play as it will stand after this cycle's CPU write; CPU writes win
  assign play_now = ctrl_wr ? bus.DIN[0] : ctrl_q[0];

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_wr ? bus.DIN[1:0] : ctrl_q;
    cnt_d      = cnt_q;
    end_l_d    = end_l_q;
    fcnt_d     = fcnt_q;
    snd_addr_d = snd_addr_q;
    sload_n_d  = 1'b1;
    sint_d     = 1'b0;
    reload     = ctrl_wr & bus.DIN[0] & ~ctrl_q[0];
    case (state_q)
      S_IDLE: begin
        if (play_now) state_d = S_ARM;
      end
      S_ARM: begin
        if (!play_now) begin
          state_d = S_IDLE;
        end else if (cnt_q == end_l_q) begin
          sint_d = 1'b1;
          // without a CPU write, play survives the frame end only in repeat mode
          if (!ctrl_wr) ctrl_d[0] = ctrl_q[1];
          if (ctrl_d[0]) reload = 1'b1;
          else           state_d = S_IDLE;
        end else if (bus.SREQ) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!play_now) begin
          state_d = S_IDLE;
        end else if (bus.snd_slot) begin
          snd_addr_d = cnt_q;
          fcnt_d     = FW'(FETCH_LAT - 2);
          state_d    = S_FETCH;
        end else if (!bus.SREQ) begin
          state_d = S_ARM;
        end
      end
      S_FETCH: begin
        // an in-flight fetch always completes, even if play was cleared
        if (fcnt_q == '0) begin
          sload_n_d = 1'b0;
          cnt_d     = cnt_q + ADDR_W'(1);
          state_d   = play_now ? S_ARM : S_IDLE;
        end else begin
          fcnt_d = fcnt_q - FW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reload) begin
      cnt_d   = start_q;
      end_l_d = end_q;
    end
  end

  always_ff @(posedge clk32) begin
    if (!resb) begin
      state_q    <= S_IDLE;
      cs_d_q     <= 1'b0;
      ctrl_q     <= '0;
      start_q    <= '0;
      end_q      <= '0;
      cnt_q      <= '0;
      end_l_q    <= '0;
      fcnt_q     <= '0;
      snd_addr_q <= '0;
      sload_n_q  <= 1'b1;
      sint_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_d_q     <= bus.CS;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      end_l_q    <= end_l_d;
      fcnt_q     <= fcnt_d;
      snd_addr_q <= snd_addr_d;
      sload_n_q  <= sload_n_d;
      sint_q     <= sint_d;
      if (wr) begin
        case (bus.A)
          5'd1: start_q[ADDR_W:16] <= bus.DIN[ADDR_W-16:0];
          5'd2: start_q[15:8]      <= bus.DIN;
          5'd3: start_q[7:1]       <= bus.DIN[7:1];
          5'd7: end_q[ADDR_W:16]   <= bus.DIN[ADDR_W-16:0];
          5'd8: end_q[15:8]        <= bus.DIN;
          5'd9: end_q[7:1]         <= bus.DIN[7:1];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd = '0;
    if (bus.CS && bus.RW) begin
      case (bus.A)
        5'd0: rd[1:0]          = ctrl_q;
        5'd1: rd[ADDR_W-16:0]  = start_q[ADDR_W:16];
        5'd2: rd[7:0]          = start_q[15:8];
        5'd3: rd[7:0]          = {start_q[7:1], 1'b0};
        5'd4: rd[ADDR_W-16:0]  = cnt_q[ADDR_W:16];
        5'd5: rd[7:0]          = cnt_q[15:8];
        5'd6: rd[7:0]          = {cnt_q[7:1], 1'b0};
        5'd7: rd[ADDR_W-16:0]  = end_q[ADDR_W:16];
        5'd8: rd[7:0]          = end_q[15:8];
        5'd9: rd[7:0]          = {end_q[7:1], 1'b0};
        default: ;
      endcase
    end
  end

  assign bus.DOUT     = rd;
  assign bus.snd_req  = (state_q == S_WAIT);
  assign bus.snd_addr = snd_addr_q;
  assign bus.SLOAD_N  = sload_n_q;
  assign bus.sint     = sint_q;
  assign bus.sactive  = ctrl_q[0];

endmodule
